instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, word address fetched first after reset.
REQ-002 SHALL have parameter ADDR_W, default 12, instruction ROM address width in words.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fetch_en  input  1  permits issue of new fetches.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target word address.
REQ-008 SHALL have port imem_addr  output  ADDR_W  address to synchronous ROM, 1-cycle read latency.
REQ-009 SHALL have port imem_data  input  32  ROM read data, mem[imem_addr of previous edge].
REQ-010 SHALL have port id_valid  output  1  instruction presented to decode.
REQ-011 SHALL have port id_ready  input  1  decode accepts presented instruction.
REQ-012 SHALL have port id_instr  output  32  presented instruction word.
REQ-013 SHALL have port id_pc  output  32  word address of presented instruction.
REQ-014 SHALL have ports perf_fetch_cnt, perf_stall_cnt  output  32 each  performance counters.

Function
REQ-015 SHALL hold fetch_pc (next address to issue), pc_q (address of word on imem_data), state in {PRIME, RUN, HOLD}.
REQ-016 SHALL drive id_valid = (state != PRIME) and not redirect_valid; id_instr = imem_data; id_pc = pc_q, all combinational.
REQ-017 SHALL define advance = fetch_en and (state == PRIME or id_ready); on advance: imem_addr = fetch_pc[ADDR_W-1:0], pc_q <= fetch_pc, fetch_pc <= fetch_pc + 1, next state RUN.
REQ-018 SHALL, when id_valid and not id_ready, drive imem_addr = pc_q[ADDR_W-1:0] and hold fetch_pc/pc_q, so imem_data stays stable; next state HOLD.
REQ-019 SHALL give redirect_valid priority over stall and fetch_en=0: imem_addr = redirect_pc[ADDR_W-1:0], pc_q <= redirect_pc, fetch_pc <= redirect_pc + 1, next state RUN; target presented the following cycle, one squashed slot.
REQ-020 SHALL, when fetch_en=0 and a presented word is accepted, go to PRIME (no new fetch); when fetch_en=0 in HOLD, stay HOLD until accepted.
REQ-021 SHALL stay in PRIME while fetch_en=0 and no redirect; imem_addr = fetch_pc[ADDR_W-1:0].
REQ-022 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFF + 1 = 0); ROM address wraps via truncation (0xFFF -> 0x000 at ADDR_W=12).
REQ-023 SHALL deliver each fetched word to decode exactly once, in program order, none lost or duplicated under any id_ready pattern.
REQ-024 SHALL have no combinational path from id_valid to id_ready (decode may depend on id_valid).

Reset
REQ-025 SHALL on rst asynchronously set fetch_pc = RESET_PC, pc_q = 0, state = PRIME, both counters = 0; id_valid = 0 while rst high.
REQ-026 SHALL, rst asserted mid-stall or mid-redirect, discard the in-flight word; first id_valid after release shows id_pc = RESET_PC.

Configuration
REQ-027 SHALL compile counters only with macro INSTR_FETCH_PERF_EN: perf_fetch_cnt +1 per cycle with id_valid and id_ready; perf_stall_cnt +1 per cycle with id_valid and not id_ready; both saturate at 32'hFFFF_FFFF.
REQ-028 SHALL, without INSTR_FETCH_PERF_EN, tie both counter ports to 0 with no counter flops.

Structure
REQ-029 SHALL place state enum (PRIME, RUN, HOLD), default RESET_PC and ADDR_W constants in shared package if_pkg.
REQ-030 SHALL implement next-address select (pc+1 / hold / redirect mux) in sub-module if_pc_next; counters and FSM in instr_fetch.

Verification
REQ-031 SHALL check reset: RESET_PC=0x10, release rst, fetch_en=1, id_ready=1 -> cycle 1 id_valid=1 id_pc=0x10, then 0x11, 0x12 on consecutive cycles.
REQ-032 SHALL check stall: id_ready=0 for 3 cycles while id_pc=0x5 -> id_pc/id_instr stable, imem_addr=0x5, perf_stall_cnt=3; after release next id_pc=0x6.
REQ-033 SHALL check redirect during stall: id_pc=0x8 stalled, redirect_valid=1 redirect_pc=0x40 -> id_valid=0 that cycle, next cycle id_pc=0x40, 0x8 never accepted.
REQ-034 SHALL check wrap: redirect_pc=0xFFF (ADDR_W=12) -> id_pc 0xFFF then 0x1000, imem_addr 0xFFF then 0x000.
REQ-035 SHALL check fetch_en drop: fetch_en=0 while id_pc=0x20 presented, id_ready=1 -> 0x20 accepted, then id_valid=0 (PRIME); fetch_en=1 -> next id_pc=0x21.
REQ-036 SHALL check counters: random id_ready over 1000 cycles -> perf_fetch_cnt equals scoreboard handshakes with macro, both 0 without.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// next-address select codes and default configuration constants.
package if_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_ADDR_W   = 12;

    // PRIME: no word on imem_data yet; RUN: fresh word presented;
    // HOLD: presented word was refused and is being re-read.
    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Next-address source chosen by the fetch FSM each cycle.
    typedef enum logic [1:0] {
        SEL_ADV   = 2'd0,  // issue fetch_pc, bump fetch_pc
        SEL_STALL = 2'd1,  // re-read pc_q so imem_data stays stable
        SEL_IDLE  = 2'd2,  // nothing issued, hold both pointers
        SEL_REDIR = 2'd3   // issue redirect_pc, restart from there
    } pc_sel_e;

endpackage

// File: rtl/if_pc_next.sv
// Next-address mux for the fetch stage: picks the ROM address driven this
// cycle and the fetch_pc / pc_q values to load at the next edge.
module if_pc_next
    import if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  pc_sel_e           i_sel,
    input  logic [31:0]       i_fetch_pc,
    input  logic [31:0]       i_pc_q,
    input  logic [31:0]       i_redirect_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_fetch_pc_nxt,
    output logic [31:0]       o_pc_q_nxt
);

    logic [31:0] w_fetch_inc;
    logic [31:0] w_redirect_inc;

    // Both increments wrap modulo 2^32; ROM address wraps by truncation.
    assign w_fetch_inc    = i_fetch_pc + 32'd1;
    assign w_redirect_inc = i_redirect_pc + 32'd1;

    // Select address and pointer updates from the FSM's choice.
    always_comb begin
        o_imem_addr    = i_fetch_pc[ADDR_W-1:0];
        o_fetch_pc_nxt = i_fetch_pc;
        o_pc_q_nxt     = i_pc_q;
        case (i_sel)
            SEL_ADV: begin
                o_imem_addr    = i_fetch_pc[ADDR_W-1:0];
                o_fetch_pc_nxt = w_fetch_inc;
                o_pc_q_nxt     = i_fetch_pc;
            end
            SEL_STALL: begin
                o_imem_addr = i_pc_q[ADDR_W-1:0];
            end
            SEL_REDIR: begin
                o_imem_addr    = i_redirect_pc[ADDR_W-1:0];
                o_fetch_pc_nxt = w_redirect_inc;
                o_pc_q_nxt     = i_redirect_pc;
            end
            default: begin
                o_imem_addr = i_fetch_pc[ADDR_W-1:0];
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a 1-cycle synchronous ROM.
// Optional performance counters are built only when INSTR_FETCH_PERF_EN
// is defined; otherwise both counter ports read 0.
//
// Decode handshake: a word transfers on a cycle where id_valid and
// id_ready are both high at the rising edge. id_valid never depends on
// id_ready, so decode may compute id_ready from id_valid. While a word is
// refused, id_pc/id_instr hold steady until it is taken or a redirect
// squashes it (redirect drops id_valid for that cycle).
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
    output state_e            dbg_state
);

    state_e      r_state;
    state_e      w_state_nxt;
    pc_sel_e     w_sel;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc_q;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_pc_q_nxt;
    logic        w_id_valid;
    logic        w_advance;

    assign w_id_valid = (r_state != PRIME) && !redirect_valid;
    assign w_advance  = fetch_en && ((r_state == PRIME) || id_ready);

    assign id_valid  = w_id_valid;
    assign id_instr  = imem_data;
    assign id_pc     = r_pc_q;
    assign dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and address select; redirect beats advance beats stall.
    always_comb begin
        w_sel       = SEL_IDLE;
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_sel       = SEL_REDIR;
            w_state_nxt = RUN;
        end else if (w_advance) begin
            w_sel       = SEL_ADV;
            w_state_nxt = RUN;
        end else if (w_id_valid && !id_ready) begin
            w_sel       = SEL_STALL;
            w_state_nxt = HOLD;
        end else begin
            // Idle in PRIME, or last word taken with fetch_en low.
            w_sel       = SEL_IDLE;
            w_state_nxt = PRIME;
        end
    end

    if_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .i_sel          (w_sel),
        .i_fetch_pc     (r_fetch_pc),
        .i_pc_q         (r_pc_q),
        .i_redirect_pc  (redirect_pc),
        .o_imem_addr    (imem_addr),
        .o_fetch_pc_nxt (w_fetch_pc_nxt),
        .o_pc_q_nxt     (w_pc_q_nxt)
    );

    // Fetch pointer and presented-word address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_pc_q     <= 32'd0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pc_q     <= w_pc_q_nxt;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Saturating counts of accepted words and refused-word cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_id_valid && id_ready && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_id_valid && !id_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, stall, redirect, wrap, fetch_en
// drop, reset mid-stall and a random-ready counter run.
module tb_instr_fetch;
    import if_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_instr;
    logic [31:0]   id_pc;
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
    state_e        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    instr_fetch #(
        .RESET_PC (32'h0000_0010),
        .ADDR_W   (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .dbg_state      (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return 32'hDEAD_0000 | {20'd0, a};
    endfunction

    // Synchronous ROM model, 1-cycle read latency.
    always @(posedge clk) imem_data <= rom_word(imem_addr);

    // Lands 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; id_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (id_valid !== 1'b0) begin $display("FAIL reset_valid: got %b exp 0", id_valid); n_fail++; end
        n_checks++;
        if (dbg_state !== PRIME) begin $display("FAIL reset_state: got %0d exp %0d", dbg_state, PRIME); n_fail++; end
        n_checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            $display("FAIL reset_cnt: got %h/%h exp 0/0", perf_fetch_cnt, perf_stall_cnt); n_fail++;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 12'h010) begin $display("FAIL reset_addr: got %h exp 010", imem_addr); n_fail++; end
        tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            e = 32'h10 + 32'(k);
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== e || id_instr !== rom_word(e[AW-1:0])) begin
                $display("FAIL reset_seq%0d: got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                         k, id_valid, id_pc, id_instr, e, rom_word(e[AW-1:0]));
                n_fail++;
            end
            tick();
            #1;
        end
    endtask

    task automatic test_stall();
        do_reset();
        fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h5; id_ready = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_addr !== 12'h005) begin
            $display("FAIL stall_redir: got v=%b a=%h exp v=0 a=005", id_valid, imem_addr); n_fail++;
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h5 || id_instr !== 32'hDEAD_0005 || imem_addr !== 12'h005) begin
                $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h a=%h exp 1/5/DEAD0005/005",
                         i, id_valid, id_pc, id_instr, imem_addr);
                n_fail++;
            end
            tick();
            #1;
        end
        n_checks++;
`ifdef INSTR_FETCH_PERF_EN
        if (perf_stall_cnt !== 32'd3) begin $display("FAIL stall_cnt: got %0d exp 3", perf_stall_cnt); n_fail++; end
`else
        if (perf_stall_cnt !== 32'd0) begin $display("FAIL stall_cnt: got %0d exp 0", perf_stall_cnt); n_fail++; end
`endif
        n_checks++;
        if (dbg_state !== HOLD || id_pc !== 32'h5) begin
            $display("FAIL stall_state: got st=%0d pc=%h exp st=%0d pc=5", dbg_state, id_pc, HOLD); n_fail++;
        end
        id_ready = 1'b1;
        #1;
        n_checks++;
        if (imem_addr !== 12'h006) begin $display("FAIL stall_rel_addr: got %h exp 006", imem_addr); n_fail++; end
        tick();
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h6 || id_instr !== 32'hDEAD_0006) begin
            $display("FAIL stall_next: got v=%b pc=%h i=%h exp 1/6/DEAD0006", id_valid, id_pc, id_instr); n_fail++;
        end
        n_checks++;
`ifdef INSTR_FETCH_PERF_EN
        if (perf_fetch_cnt !== 32'd1) begin $display("FAIL stall_fcnt: got %0d exp 1", perf_fetch_cnt); n_fail++; end
`else
        if (perf_fetch_cnt !== 32'd0) begin $display("FAIL stall_fcnt: got %0d exp 0", perf_fetch_cnt); n_fail++; end
`endif
    endtask

    task automatic test_redirect_stall();
        int acc8;
        acc8 = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h8; id_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
            $display("FAIL rds_pres: got v=%b pc=%h exp 1/8", id_valid, id_pc); n_fail++;
        end
        if (id_valid && id_ready && id_pc == 32'h8) acc8++;
        tick();
        #1;
        if (id_valid && id_ready && id_pc == 32'h8) acc8++;
        redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_addr !== 12'h040) begin
            $display("FAIL rds_squash: got v=%b a=%h exp 0/040", id_valid, imem_addr); n_fail++;
        end
        if (id_valid && id_ready && id_pc == 32'h8) acc8++;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'hDEAD_0040) begin
            $display("FAIL rds_target: got v=%b pc=%h i=%h exp 1/40/DEAD0040", id_valid, id_pc, id_instr); n_fail++;
        end
        if (id_valid && id_ready && id_pc == 32'h8) acc8++;
        tick();
        #1;
        n_checks++;
        if (id_pc !== 32'h41) begin $display("FAIL rds_after: got pc=%h exp 41", id_pc); n_fail++; end
        n_checks++;
        if (acc8 !== 0) begin $display("FAIL rds_no8: got %0d accepts exp 0", acc8); n_fail++; end
    endtask

    task automatic test_wrap();
        fetch_en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFF;
        #1;
        n_checks++;
        if (imem_addr !== 12'hFFF) begin $display("FAIL wrap_a0: got %h exp FFF", imem_addr); n_fail++; end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (id_pc !== 32'hFFF || id_instr !== 32'hDEAD_0FFF || imem_addr !== 12'h000) begin
            $display("FAIL wrap_fff: got pc=%h i=%h a=%h exp FFF/DEAD0FFF/000", id_pc, id_instr, imem_addr); n_fail++;
        end
        tick();
        #1;
        n_checks++;
        if (id_pc !== 32'h1000 || id_instr !== 32'hDEAD_0000 || imem_addr !== 12'h001) begin
            $display("FAIL wrap_1000: got pc=%h i=%h a=%h exp 1000/DEAD0000/001", id_pc, id_instr, imem_addr); n_fail++;
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (id_pc !== 32'hFFFF_FFFF || id_instr !== 32'hDEAD_0FFF) begin
            $display("FAIL wrap32_top: got pc=%h i=%h exp FFFFFFFF/DEAD0FFF", id_pc, id_instr); n_fail++;
        end
        tick();
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hDEAD_0000) begin
            $display("FAIL wrap32_zero: got v=%b pc=%h i=%h exp 1/0/DEAD0000", id_valid, id_pc, id_instr); n_fail++;
        end
    endtask

    task automatic test_fetch_en_drop();
        fetch_en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        fetch_en = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h20) begin
            $display("FAIL fen_pres: got v=%b pc=%h exp 1/20", id_valid, id_pc); n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            n_checks++;
            if (id_valid !== 1'b0 || dbg_state !== PRIME) begin
                $display("FAIL fen_prime%0d: got v=%b st=%0d exp 0/%0d", i, id_valid, dbg_state, PRIME); n_fail++;
            end
        end
        fetch_en = 1'b1;
        #1;
        n_checks++;
        if (imem_addr !== 12'h021) begin $display("FAIL fen_addr: got %h exp 021", imem_addr); n_fail++; end
        tick();
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h21 || id_instr !== 32'hDEAD_0021) begin
            $display("FAIL fen_resume: got v=%b pc=%h i=%h exp 1/21/DEAD0021", id_valid, id_pc, id_instr); n_fail++;
        end
    endtask

    task automatic test_reset_mid_stall();
        fetch_en = 1'b1; id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick();
        redirect_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (id_valid !== 1'b0) begin $display("FAIL rst_async: got v=%b exp 0", id_valid); n_fail++; end
        tick();
        rst = 1'b0; id_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== 32'hDEAD_0010) begin
            $display("FAIL rst_first: got v=%b pc=%h i=%h exp 1/10/DEAD0010", id_valid, id_pc, id_instr); n_fail++;
        end
    endtask

    task automatic test_counters();
        int hs;
        int st;
        logic [31:0] e;
        hs = 0; st = 0;
        exp_q.delete();
        for (int k = 0; k < 1000; k++) exp_q.push_back(32'h10 + 32'(k));
        do_reset();
        fetch_en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            id_ready = 1'($urandom_range(0, 1));
            #1;
            if (id_valid && id_ready) begin
                e = exp_q.pop_front();
                hs++;
                n_checks++;
                if (id_pc !== e || id_instr !== rom_word(e[AW-1:0])) begin
                    $display("FAIL order: got pc=%h i=%h exp pc=%h i=%h", id_pc, id_instr, e, rom_word(e[AW-1:0]));
                    n_fail++;
                end
            end else if (id_valid) begin
                st++;
            end
            tick();
        end
        #1;
        n_checks++;
`ifdef INSTR_FETCH_PERF_EN
        if (perf_fetch_cnt !== 32'(hs) || perf_stall_cnt !== 32'(st)) begin
            $display("FAIL cnt_run: got %0d/%0d exp %0d/%0d", perf_fetch_cnt, perf_stall_cnt, hs, st); n_fail++;
        end
`else
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            $display("FAIL cnt_run: got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); n_fail++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_fetch_en_drop();
        test_reset_mid_stall();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
